cm0_mtx_wrr_arb: RTL

Weighted round-robin output arbiter for a multi-port bus matrix output stage. It selects which of NUM_PORTS input stages owns the shared AHB-Lite slave port. Arbitration honours locked transfers and fixed-length bursts, and gives each port a configurable quantum of NONSEQ transfers per grant. It drives the address-phase mux select (addr_in_port) and the no_port indication into the output stage.

---
 rtl/cm0_mtx_wrr_arb.sv | 131 +++++++++++++
 1 files changed

// File: rtl/cm0_mtx_wrr_arb.sv
// cm0_mtx_wrr_arb: weighted round-robin owner select for a bus-matrix output stage
// Ports: HCLK/HRESETn (async active-low) clock and reset; req_port per-port request;
//   weight_cfg per-port NONSEQ quantum; HREADYM/HSELM/HTRANSM/HBURSTM/HMASTLOCKM the
//   current owner's slave-side transfer; addr_in_port granted port; no_port nobody
//   granted; grant_change one-cycle pulse after a committed grant change.
// Option: define CM0_MTX_WRR_STARVE_EN for per-port wait counters that force a grant
//   to any port waiting STARVE_LIMIT or more cycles.
module cm0_mtx_wrr_arb #(
  parameter int NUM_PORTS    = 4,
  parameter int PORT_W       = 2,
  parameter int WEIGHT_W     = 4,
  parameter int STARVE_LIMIT = 32
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic [NUM_PORTS-1:0]          req_port,
  input  logic [NUM_PORTS*WEIGHT_W-1:0] weight_cfg,
  input  logic                          HREADYM,
  input  logic                          HSELM,
  input  logic [1:0]                    HTRANSM,
  input  logic [2:0]                    HBURSTM,
  input  logic                          HMASTLOCKM,
  output logic [PORT_W-1:0]             addr_in_port,
  output logic                          no_port,
  output logic                          grant_change
);
  localparam logic [1:0] T_IDLE = 2'd0, T_NONSEQ = 2'd2, T_SEQ = 2'd3;
  if (NUM_PORTS < 2 || PORT_W < $clog2(NUM_PORTS) || STARVE_LIMIT < 1) begin : g_bad_params
    $error("cm0_mtx_wrr_arb: illegal parameter set");
  end
  logic [PORT_W-1:0]   owner_q, owner_d, pick, spick, gnt;
  logic                no_port_q, no_port_d, gc_q, hold_q, hold_d, found, grab;
  logic [3:0]          remain_q, remain_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d, credit_dec, w_gnt;
  logic                unused_ok;
  assign unused_ok = &{1'b0, HBURSTM[0]};
  function automatic logic bit_at(input logic [NUM_PORTS-1:0] v, input int i);
    return |(v & (NUM_PORTS'(1) << i));
  endfunction
  // Beat tracker: HBURSTM[2:1] encodes 4/8/16-beat bursts regardless of wrap/incr.
  always_comb begin
    remain_d = remain_q;
    hold_d   = hold_q;
    if (!HSELM || HTRANSM == T_IDLE) begin
      remain_d = '0;
      hold_d   = 1'b0;
    end else if (HTRANSM == T_NONSEQ) begin
      remain_d = HBURSTM[2:1] == 2'b01 ? 4'd3 : HBURSTM[2:1] == 2'b10 ? 4'd7 :
                 HBURSTM[2:1] == 2'b11 ? 4'd15 : 4'd0;
      hold_d   = HBURSTM[2:1] != 2'b00;
    end else if (HTRANSM == T_SEQ) begin
      remain_d = remain_q == '0 ? '0 : remain_q - 4'd1;
      hold_d   = remain_q > 4'd1;
    end
  end
`ifdef CM0_MTX_WRR_STARVE_EN
  logic [NUM_PORTS-1:0][7:0] wait_q;
  logic [NUM_PORTS-1:0]      starved;
  always_comb begin
    spick = '0;
    for (int k = 0; k < NUM_PORTS; k++)
      starved[k] = req_port[k] && int'(wait_q[k]) >= STARVE_LIMIT;
    for (int k = NUM_PORTS - 1; k >= 0; k--)
      if (bit_at(starved, k)) spick = PORT_W'(k);
  end
  assign grab = |starved;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) wait_q <= '0;
    else if (HREADYM)
      for (int k = 0; k < NUM_PORTS; k++)
        wait_q[k] <= (!req_port[k] || (!no_port_d && int'(owner_d) == k)) ? 8'd0 :
                     ((no_port_q || int'(owner_q) != k) && wait_q[k] != 8'hFF) ? wait_q[k] + 8'd1 :
                     wait_q[k];
`else
  assign grab  = 1'b0;
  assign spick = '0;
`endif
  // Rotating search starts after the owner; with no owner it starts at port 0.
  always_comb begin
    int base;
    found = 1'b0;
    pick  = owner_q;
    base  = no_port_q ? NUM_PORTS - 1 : int'(owner_q);
    for (int k = 1; k <= NUM_PORTS; k++) begin
      int idx;
      idx = (base + k) % NUM_PORTS;
      if (!found && bit_at(req_port, idx)) begin
        found = 1'b1;
        pick  = PORT_W'(idx);
      end
    end
  end
  assign gnt   = grab ? spick : pick;
  assign w_gnt = WEIGHT_W'(weight_cfg >> (int'(gnt) * WEIGHT_W));
  always_comb begin
    credit_dec = (HSELM && HTRANSM == T_NONSEQ && credit_q != '0) ? credit_q - 1'b1 : credit_q;
    owner_d    = owner_q;
    no_port_d  = no_port_q;
    credit_d   = credit_dec;
    if (HMASTLOCKM || hold_d) begin
      owner_d = owner_q;
    end else if (grab || (found && (no_port_q || !bit_at(req_port, int'(owner_q)) || credit_dec == '0))) begin
      owner_d   = gnt;
      no_port_d = 1'b0;
      credit_d  = w_gnt == '0 ? WEIGHT_W'(1) : w_gnt;
    end else if (!found && (no_port_q || !HSELM)) begin
      no_port_d = 1'b1;
    end
  end
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      owner_q   <= '0;
      no_port_q <= 1'b1;
      gc_q      <= 1'b0;
      remain_q  <= '0;
      hold_q    <= 1'b0;
      credit_q  <= '0;
    end else begin
      gc_q <= HREADYM && (owner_d != owner_q || no_port_d != no_port_q);
      if (HREADYM) begin
        owner_q   <= owner_d;
        no_port_q <= no_port_d;
        remain_q  <= remain_d;
        hold_q    <= hold_d;
        credit_q  <= credit_d;
      end
    end
  assign addr_in_port = owner_q;
  assign no_port      = no_port_q;
  assign grant_change = gc_q;
endmodule
